// File: rtl/seq_rotl_shifter_if.sv
// Request/result bundle for seq_rotl_shifter: the execute controller drives
// start/in/cnt/op (master) and the shifter returns out/busy/done (slave).
interface seq_rotl_shifter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] in;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start, in, cnt, op,
        input  out, busy, done
    );

    modport slave (
        input  start, in, cnt, op,
        output out, busy, done
    );
endinterface

// File: rtl/seq_rotl_shifter.sv
// Multi-cycle rotate/shift unit resolving one power-of-two stage per clock.
// Optional macro ROTL_EARLY_DONE_EN ends the sequence after the highest set cnt bit.
module seq_rotl_shifter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    seq_rotl_shifter_if.slave    bus
);
    localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [STG_W-1:0] r_stage;
    logic [WIDTH-1:0] r_work;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_out;

    state_t           w_state_next;
    logic [STG_W-1:0] w_stage_next;
    logic [WIDTH-1:0] w_work_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_op_next;
    logic [WIDTH-1:0] w_out_next;

    logic [CNT_W-1:0][WIDTH-1:0] w_cand;
    logic [WIDTH-1:0]            w_step;
    logic [STG_W-1:0]            w_last;

    // Each stage k = 2^gi has its own fixed-amount shifter; r_stage picks one.
    genvar gi;
    generate
        for (gi = 0; gi < CNT_W; gi++) begin : g_stage
            localparam int K = 1 << gi;
            logic [WIDTH-1:0] w_rol;
            logic [WIDTH-1:0] w_sra;
            assign w_rol = {r_work[WIDTH-1-K:0], r_work[WIDTH-1:WIDTH-K]};
            assign w_sra = WIDTH'($signed(r_work) >>> K);
            assign w_cand[gi] = (r_op == OP_ROL) ? w_rol :
                                (r_op == OP_SLL) ? (r_work << K) :
                                (r_op == OP_SRA) ? w_sra :
                                                   (r_work >> K);
        end
    endgenerate

    assign w_step = r_cnt[r_stage] ? w_cand[r_stage] : r_work;

`ifdef ROTL_EARLY_DONE_EN
    always_comb begin
        w_last = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (r_cnt[i]) begin
                w_last = STG_W'(i);
            end
        end
    end
`else
    assign w_last = STG_W'(CNT_W - 1);
`endif

    always_comb begin
        w_state_next = r_state;
        w_stage_next = r_stage;
        w_work_next  = r_work;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_out_next   = r_out;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_work_next  = bus.in;
                    w_cnt_next   = bus.cnt;
                    w_op_next    = bus.op;
                    w_stage_next = '0;
                    w_state_next = S_SHIFT;
`ifdef ROTL_EARLY_DONE_EN
                    // Zero amount has nothing to resolve: publish the operand now.
                    if (bus.cnt == '0) begin
                        w_out_next   = bus.in;
                        w_state_next = S_DONE;
                    end
`endif
                end
            end
            S_SHIFT: begin
                w_work_next = w_step;
                if (r_stage == w_last) begin
                    w_out_next   = w_step;
                    w_state_next = S_DONE;
                end else begin
                    w_stage_next = r_stage + STG_W'(1);
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_stage <= '0;
            r_work  <= '0;
            r_cnt   <= '0;
            r_op    <= '0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_next;
            r_stage <= w_stage_next;
            r_work  <= w_work_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_out   <= w_out_next;
        end
    end

    assign bus.out  = r_out;
    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = (r_state == S_DONE);
endmodule

// File: tb/tb_seq_rotl_shifter.sv
// Directed-vector bench for seq_rotl_shifter: stimulus pushes expected results
// into a queue, a negedge monitor pops and compares on every done pulse.
module tb_seq_rotl_shifter;
    localparam logic [1:0] ROL = 2'b00;
    localparam logic [1:0] SLL = 2'b01;
    localparam logic [1:0] SRA = 2'b10;
    localparam logic [1:0] SRL = 2'b11;

    typedef struct {
        logic [15:0] val;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sb[$];

    seq_rotl_shifter_if #(.WIDTH(16), .CNT_W(4)) bus ();

    seq_rotl_shifter #(.WIDTH(16), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input logic [3:0] c);
`ifdef ROTL_EARLY_DONE_EN
        int m = -1;
        for (int i = 0; i < 4; i++) if (c[i]) m = i;
        return m + 2;
`else
        return 5;
`endif
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: cycle %0d out=0x%04h, expected no done", cyc, bus.out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out !== e.val || cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL %s: out=0x%04h at cycle %0d, expected 0x%04h at cycle %0d",
                             e.name, bus.out, cyc, e.val, e.cyc);
                end else begin
                    $display("ok   %s: out=0x%04h at cycle %0d", e.name, bus.out, cyc);
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the next one.
    task automatic issue(input string name, input logic [15:0] din, input logic [3:0] c,
                         input logic [1:0] o, input logic [15:0] exp);
        exp_t e;
        bus.start = 1'b1;
        bus.in    = din;
        bus.cnt   = c;
        bus.op    = o;
        e.val  = exp;
        e.cyc  = cyc + lat(c);
        e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name);
        int g = 0;
        while (sb.size() != 0 && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [15:0] din, input logic [3:0] c,
                       input logic [1:0] o, input logic [15:0] exp);
        issue(name, din, c, o, exp);
        drain(name);
    endtask

    initial begin
        int c0;
        int l;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.in    = '0;
        bus.cnt   = '0;
        bus.op    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", bus.out, 16'h0000);
        check("reset_busy", {15'b0, bus.busy}, 16'h0000);
        check("reset_done", {15'b0, bus.done}, 16'h0000);
        rst = 1'b0;
        @(posedge clk); #1;

        // First operation with busy tracked cycle by cycle.
        c0 = cyc;
        l  = lat(4'd4);
        issue("rol_1234_4", 16'h1234, 4'd4, ROL, 16'h2341);
        check("busy_c1", {15'b0, bus.busy}, 16'h0001);
        for (int i = 2; i <= l + 1; i++) begin
            @(posedge clk); #1;
            check($sformatf("busy_c%0d", i), {15'b0, bus.busy}, (i <= l) ? 16'h0001 : 16'h0000);
        end
        check("hold_after_done", bus.out, 16'h2341);
        drain("rol_1234_4");

        run("sll_1234_4",  16'h1234, 4'd4,  SLL, 16'h2340);
        run("srl_1234_4",  16'h1234, 4'd4,  SRL, 16'h0123);
        run("sra_1234_4",  16'h1234, 4'd4,  SRA, 16'h0123);
        run("sra_8001_1",  16'h8001, 4'd1,  SRA, 16'hC000);
        run("srl_8001_1",  16'h8001, 4'd1,  SRL, 16'h4000);
        run("srl_8001_15", 16'h8001, 4'd15, SRL, 16'h0001);
        run("sll_8001_15", 16'h8001, 4'd15, SLL, 16'h8000);
        run("sra_8001_15", 16'h8001, 4'd15, SRA, 16'hFFFF);
        run("rol_8001_15", 16'h8001, 4'd15, ROL, 16'hC000);
        run("rol_beef_0",  16'hBEEF, 4'd0,  ROL, 16'hBEEF);
        run("rol_beef_4",  16'hBEEF, 4'd4,  ROL, 16'hEEFB);
        run("sll_beef_8",  16'hBEEF, 4'd8,  SLL, 16'hEF00);
        run("sra_beef_8",  16'hBEEF, 4'd8,  SRA, 16'hFFBE);
        run("srl_beef_8",  16'hBEEF, 4'd8,  SRL, 16'h00BE);

        // Start while busy must be ignored; start right after done accepted.
        issue("first_a5c3", 16'hA5C3, 4'd12, ROL, 16'h3A5C);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.in    = 16'hFFFF;
        bus.cnt   = 4'd1;
        bus.op    = SLL;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain("first_a5c3");
        run("next_00f0", 16'h00F0, 4'd2, SRL, 16'h003C);
        @(posedge clk); #1;
        check("idle_hold", bus.out, 16'h003C);

        // Reset mid-SHIFT discards the operation.
        bus.start = 1'b1;
        bus.in    = 16'h1234;
        bus.cnt   = 4'd8;
        bus.op    = ROL;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("busy_before_rst", {15'b0, bus.busy}, 16'h0001);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", {15'b0, bus.busy}, 16'h0000);
        check("abort_done", {15'b0, bus.done}, 16'h0000);
        check("abort_out", bus.out, 16'h0000);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // Reset and start together: reset wins.
        rst       = 1'b1;
        bus.start = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", {15'b0, bus.busy}, 16'h0000);
        @(posedge clk); #1;

        run("fresh_1234_8", 16'h1234, 4'd8, ROL, 16'h3412);
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
